// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locked arbiter for the single write port of the
// CL-to-kernel FIFO. One requester is granted at a time and keeps the grant until its
// last beat is accepted. Beats are only accepted while the FIFO has room, so a write is
// never issued to a full FIFO. The FIFO write strobe and data are registered.
//
// Ports:
//   clk_main_a0      main clock
//   rst_main_n_sync  asynchronous active-low reset
//   req_valid/last   per-requester beat valid / last beat of packet
//   req_data         per-requester data, requester i at [i*DATA_W +: DATA_W]
//   req_ready        per-requester beat accepted this cycle (combinational)
//   fifo_size        current FIFO occupancy
//   fifo_wr/din      registered FIFO write strobe / data
//   grant_id         current or most recent granted requester
//   busy             high while a packet is locked
//   pkt_count        completed packets across all requesters (wraps)
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SIZE_W     = 8
) (
  input  logic                    clk_main_a0,
  input  logic                    rst_main_n_sync,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [SIZE_W-1:0]       fifo_size,
  output logic                    fifo_wr,
  output logic [DATA_W-1:0]       fifo_din,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic [15:0]             pkt_count
);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e              state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          grant_q, grant_d;
  logic                fifo_wr_q, fifo_wr_d;
  logic [DATA_W-1:0]   fifo_din_q, fifo_din_d;
  logic [15:0]         pkt_count_q, pkt_count_d;

  logic [SIZE_W:0]     occ;
  logic                space;
  logic                pick_valid;
  logic [2:0]          pick_id;
  logic                accept;
  logic                acc_last;
  logic [DATA_W-1:0]   acc_data;

  // fifo_size lags fifo_wr by one cycle, so count the write still in flight.
  assign occ   = {1'b0, fifo_size} + {{SIZE_W{1'b0}}, fifo_wr_q};
  assign space = occ < (SIZE_W+1)'(FIFO_DEPTH);

  // Round-robin pick: first valid requester after the pointer, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = ptr_q;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      for (int j = 0; j < int'(N_REQ); j++) begin
        if (!pick_valid && req_valid[j] && (((int'(ptr_q) + k) % int'(N_REQ)) == j)) begin
          pick_valid = 1'b1;
          pick_id    = 3'(j);
        end
      end
    end
  end

  // Only the locked requester can be accepted, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    acc_last  = 1'b0;
    acc_data  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (state_q == StLock && grant_q == 3'(i)) begin
        req_ready[i] = req_valid[i] & space;
        accept       = req_valid[i] & space;
        acc_last     = req_last[i];
        acc_data     = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    pkt_count_d = pkt_count_q;
    fifo_wr_d   = accept;
    fifo_din_d  = accept ? acc_data : fifo_din_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_id;
          state_d = StLock;
        end
      end
      StLock: begin
        if (accept && acc_last) begin
          state_d     = StIdle;
          ptr_d       = grant_q;
          pkt_count_d = pkt_count_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
    if (!rst_main_n_sync) begin
      state_q     <= StIdle;
      ptr_q       <= 3'(N_REQ - 1);
      grant_q     <= '0;
      fifo_wr_q   <= 1'b0;
      fifo_din_q  <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_din_q  <= fifo_din_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign fifo_wr   = fifo_wr_q;
  assign fifo_din  = fifo_din_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == StLock);
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed packets from two requesters, a transaction-level
// reference model compared every cycle, and literal expectations on the write log.
module tb_fifo_wr_arbiter;
  localparam int N     = 2;
  localparam int W     = 32;
  localparam int DEPTH = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  rv    = '0;
  logic [N-1:0]  rl    = '0;
  logic [N*W-1:0] rd   = '0;
  logic [7:0]    fsz   = '0;
  logic [N-1:0]  req_ready;
  logic          fifo_wr;
  logic [W-1:0]  fifo_din;
  logic [2:0]    grant_id;
  logic          busy;
  logic [15:0]   pkt_count;

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DATA_W    (W),
    .FIFO_DEPTH(DEPTH),
    .SIZE_W    (8)
  ) dut (
    .clk_main_a0    (clk),
    .rst_main_n_sync(rst_n),
    .req_valid      (rv),
    .req_last       (rl),
    .req_data       (rd),
    .req_ready      (req_ready),
    .fifo_size      (fsz),
    .fifo_wr        (fifo_wr),
    .fifo_din       (fifo_din),
    .grant_id       (grant_id),
    .busy           (busy),
    .pkt_count      (pkt_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: who owns the port, who finished last, what was written.
  int          m_owner = -1;
  int          m_gnt   = 0;
  int          m_rr    = N - 1;
  int          m_pkts  = 0;
  bit          m_wr    = 1'b0;
  logic [W-1:0] m_din  = '0;

  initial begin : model
    bit sp;
    bit found;
    int j;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_gnt = 0; m_rr = N - 1; m_pkts = 0; m_wr = 1'b0; m_din = '0;
      end else begin
        sp = (int'(fsz) + int'(m_wr)) < DEPTH;
        if (m_owner < 0) begin
          m_wr  = 1'b0;
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            j = (m_rr + k) % N;
            if (!found && rv[j]) begin
              found   = 1'b1;
              m_owner = j;
              m_gnt   = j;
            end
          end
        end else if (rv[m_owner] && sp) begin
          m_wr  = 1'b1;
          m_din = rd[m_owner*W +: W];
          if (rl[m_owner]) begin
            m_pkts  = (m_pkts + 1) % 65536;
            m_rr    = m_owner;
            m_owner = -1;
          end
        end else begin
          m_wr = 1'b0;
        end
      end
    end
  end

  logic [W-1:0] wr_log[$];
  int           gnt_log[$];
  int           cyc_log[$];

  // Every-cycle comparison against the model, plus a log of FIFO writes.
  initial begin : compare
    logic [N-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      exp_rdy = '0;
      if (m_owner >= 0 && rv[m_owner] && ((int'(fsz) + int'(m_wr)) < DEPTH))
        exp_rdy[m_owner] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("fifo_wr",   64'(fifo_wr),   64'(m_wr));
      chk("fifo_din",  64'(fifo_din),  64'(m_din));
      chk("grant_id",  64'(grant_id),  64'(m_gnt));
      chk("busy",      64'(busy),      64'(m_owner >= 0));
      chk("pkt_count", 64'(pkt_count), 64'(m_pkts));
      if (fifo_wr === 1'b1) begin
        wr_log.push_back(fifo_din);
        gnt_log.push_back(int'(grant_id));
        cyc_log.push_back(cyc);
      end
    end
  end

  function automatic logic [63:0] wlog(input int i);
    return (i < wr_log.size()) ? 64'(wr_log[i]) : 64'hDEAD_BEEF_0000;
  endfunction
  function automatic int glog(input int i);
    return (i < gnt_log.size()) ? gnt_log[i] : -1;
  endfunction
  function automatic int clog(input int i);
    return (i < cyc_log.size()) ? cyc_log[i] : -1;
  endfunction

  task automatic clear_logs();
    wr_log.delete(); gnt_log.delete(); cyc_log.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  // Drive one packet; optional valid gap of gap_len cycles after beat gap_at is accepted.
  task automatic send_pkt(input int r, input int nb, input logic [W-1:0] base,
                          input logic [W-1:0] step, input int gap_at, input int gap_len);
    int i   = 0;
    int tmo = 0;
    bit rdy;
    while (i < nb) begin
      if (!rst_n) begin
        rv[r] = 1'b0; rl[r] = 1'b0;
        return;
      end
      rv[r] = 1'b1;
      rl[r] = (i == nb - 1);
      rd[r*W +: W] = base + W'(i) * step;
      @(negedge clk);
      rdy = req_ready[r];
      @(posedge clk); #2;
      if (rdy) begin
        i++;
        tmo = 0;
        if (i - 1 == gap_at && gap_len > 0 && i < nb) begin
          rv[r] = 1'b0; rl[r] = 1'b0;
          idle(gap_len);
        end
      end else if (++tmo > 200) begin
        n_tests++; n_fail++;
        $display("FAIL send_pkt_timeout: requester %0d stuck at beat %0d", r, i);
        rv[r] = 1'b0; rl[r] = 1'b0;
        return;
      end
    end
    rv[r] = 1'b0; rl[r] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int n_before;
    idle(2);
    chk("rst_fifo_wr",   64'(fifo_wr),   64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_grant_id",  64'(grant_id),  64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    idle(1);

    // Single 3-beat packet from requester 0.
    clear_logs();
    t0 = cyc;
    send_pkt(0, 3, 32'h11, 32'h11, -1, 0);
    idle(3);
    chk("t1_nwrites",    64'(wr_log.size()), 64'd3);
    chk("t1_din0",       wlog(0), 64'h11);
    chk("t1_din1",       wlog(1), 64'h22);
    chk("t1_din2",       wlog(2), 64'h33);
    chk("t1_latency",    64'(clog(0) - t0), 64'd2);
    chk("t1_back2back",  64'(clog(2) - clog(0)), 64'd2);
    chk("t1_pkt_count",  64'(pkt_count), 64'd1);
    chk("t1_busy",       64'(busy), 64'd0);

    // Both requesters, 1-beat packets: grants alternate from reset.
    do_reset();
    clear_logs();
    fork
      begin
        send_pkt(0, 1, 32'hA0, 32'h0, -1, 0);
        send_pkt(0, 1, 32'hA1, 32'h0, -1, 0);
      end
      begin
        send_pkt(1, 1, 32'hB0, 32'h0, -1, 0);
        send_pkt(1, 1, 32'hB1, 32'h0, -1, 0);
      end
    join
    idle(3);
    chk("t2_g0", 64'(glog(0)), 64'd0);
    chk("t2_g1", 64'(glog(1)), 64'd1);
    chk("t2_g2", 64'(glog(2)), 64'd0);
    chk("t2_g3", 64'(glog(3)), 64'd1);
    chk("t2_d1", wlog(1), 64'hB0);
    chk("t2_d2", wlog(2), 64'hA1);
    chk("t2_spacing", 64'(clog(3) - clog(0)), 64'd6);
    chk("t2_pkt_count", 64'(pkt_count), 64'd4);

    // Full throttle: one write at size 15, none at 16, resume at 14.
    clear_logs();
    fsz = 8'd15;
    fork
      send_pkt(1, 3, 32'hC0, 32'h1, -1, 0);
      begin
        int tmo = 0;
        while (wr_log.size() < 1 && tmo < 50) begin
          idle(1); tmo++;
        end
        fsz = 8'd16;
        idle(6);
        chk("t3_full_writes", 64'(wr_log.size()), 64'd1);
        fsz = 8'd14;
      end
    join
    idle(2);
    fsz = 8'd0;
    chk("t3_nwrites", 64'(wr_log.size()), 64'd3);
    chk("t3_d0", wlog(0), 64'hC0);
    chk("t3_d1", wlog(1), 64'hC1);
    chk("t3_d2", wlog(2), 64'hC2);

    // Requester 0 stalls mid-packet; requester 1 waits for the lock to drop.
    clear_logs();
    fork
      send_pkt(0, 3, 32'hD0, 32'h1, 0, 5);
      begin
        idle(1);
        send_pkt(1, 1, 32'hE0, 32'h0, -1, 0);
      end
    join
    idle(3);
    chk("t4_d0", wlog(0), 64'hD0);
    chk("t4_d2", wlog(2), 64'hD2);
    chk("t4_d3", wlog(3), 64'hE0);
    chk("t4_grant_id", 64'(grant_id), 64'd1);

    // Asynchronous reset mid-packet.
    clear_logs();
    fork
      send_pkt(0, 4, 32'hF0, 32'h1, -1, 0);
      begin
        idle(2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t5_fifo_wr",   64'(fifo_wr),   64'd0);
        chk("t5_busy",      64'(busy),      64'd0);
        chk("t5_pkt_count", 64'(pkt_count), 64'd0);
        chk("t5_req_ready", 64'(req_ready), 64'd0);
      end
    join
    idle(1);
    rst_n = 1'b1;
    clear_logs();
    fork
      send_pkt(1, 1, 32'h71, 32'h0, -1, 0);
      send_pkt(0, 1, 32'h70, 32'h0, -1, 0);
    join
    idle(3);
    chk("t5_nwrites", 64'(wr_log.size()), 64'd2);
    chk("t5_g0", 64'(glog(0)), 64'd0);
    chk("t5_g1", 64'(glog(1)), 64'd1);
    chk("t5_d0", wlog(0), 64'h70);

    // Packet counter wrap, starting just below 0xFFFF.
    @(posedge clk); #2;
    force dut.pkt_count_q = 16'hFFFD;
    m_pkts = 16'hFFFD;
    idle(1);
    release dut.pkt_count_q;
    n_before = 0;
    repeat (2) begin
      send_pkt(0, 1, 32'h5A, 32'h0, -1, 0);
      n_before++;
    end
    idle(2);
    chk("t6_pkt_ffff", 64'(pkt_count), 64'hFFFF);
    send_pkt(0, 1, 32'h5B, 32'h0, -1, 0);
    idle(2);
    chk("t6_pkt_wrap", 64'(pkt_count), 64'd0);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single write port of the CL-to-kernel FIFO (32-bit FIFO_Shanquan instance) between N requesters, e.g. the AXI-lite write path and a DMA/stream source.
- Sits between the requesters and the FIFO wr/din/size pins.
- Grants one requester at a time and holds the grant until that requester's last beat is accepted.
- Throttles using the FIFO occupancy, so no write is ever issued to a full FIFO.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- DATA_W, 32, data width per requester and FIFO din width
- FIFO_DEPTH, 16, FIFO capacity in words; must match the instantiated FIFO
- SIZE_W, 8, width of the FIFO size port

Ports:
- clk_main_a0  in  1  main clock
- rst_main_n_sync  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  N_REQ  per-requester beat valid
- req_last  in  N_REQ  per-requester last beat of packet (qualified by req_valid)
- req_data  in  N_REQ*DATA_W  per-requester beat data; requester i at [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  per-requester beat accepted this cycle (combinational)
- fifo_size  in  SIZE_W  current FIFO occupancy
- fifo_wr  out  1  registered FIFO write strobe
- fifo_din  out  DATA_W  registered FIFO write data
- grant_id  out  3  index of the current or last granted requester
- busy  out  1  high while in LOCK
- pkt_count  out  16  completed packets, all requesters

Behaviour:
- Reset (async assert, sync release) values:
  - fifo_wr=0, fifo_din=0, grant_id=0, busy=0, pkt_count=0, req_ready=0.
  - State=IDLE; rr pointer=N_REQ-1, so requester 0 has first priority.
- Space check:
  - space = (fifo_size + fifo_wr) < FIFO_DEPTH, computed at SIZE_W+1 bits.
  - The fifo_wr term covers the write still in flight, because fifo_size updates one cycle after wr.
- State IDLE:
  - If any req_valid is set, select the first set bit scanning ptr+1, ptr+2, ... modulo N_REQ.
  - Register it into grant_id and go to LOCK. busy=1 from the next cycle.
  - No beat is accepted in IDLE.
- State LOCK:
  - req_ready[grant_id] = req_valid[grant_id] & space. All other req_ready bits are 0.
  - Accept = req_valid & req_ready for the granted requester.
  - On accept: next cycle fifo_wr=1 and fifo_din=that requester's req_data; otherwise fifo_wr=0 and fifo_din holds.
  - Accept with req_last: go to IDLE, ptr<=grant_id, pkt_count<=pkt_count+1 (wraps 0xFFFF->0).
  - Granted requester deasserts valid mid-packet: stay in LOCK indefinitely; other requesters are not served.
- Throughput and latency:
  - 1 beat/cycle inside a packet while space holds.
  - 1-cycle arbitration bubble between packets.
  - Req accept to fifo_wr: 1 cycle.
- Simultaneous events:
  - req_valid from several requesters at once: rr order decides.
  - A requester whose valid rises in the same cycle as another's last accept competes in the next IDLE cycle.
- Full boundary:
  - With fifo_size=FIFO_DEPTH-1 and fifo_wr=1, space=0 and req_ready stays 0.
  - fifo_size=FIFO_DEPTH never produces fifo_wr.
- Reset mid-packet: everything returns to reset values immediately; the partial packet is dropped and never resumed.
- grant_id holds its value in IDLE until the next grant.

Test Plan:
- Single req0, 3-beat packet 0x11,0x22,0x33 (last on 0x33), FIFO empty -> fifo_wr high 3 consecutive cycles with din 0x11,0x22,0x33; first fifo_wr 2 cycles after req_valid rises; pkt_count=1; busy back to 0.
- req0 and req1 both valid continuously with 1-beat packets -> grants alternate 0,1,0,1; one write every 2 cycles; after 4 packets pkt_count=4.
- Full throttle: fifo_size held at 15 (DEPTH 16), req1 valid -> exactly one write; then req_ready stays 0 while size reads 16; lower size to 14 -> transfers resume, no data lost or duplicated.
- req0 packet in progress drops valid for 5 cycles while req1 is valid -> req1 never gets req_ready until req0's last beat is accepted; then grant_id=1.
- Assert rst_main_n_sync low mid-packet, asynchronously between clock edges -> fifo_wr=0, busy=0, pkt_count=0 immediately; after release, req1 and req0 both valid -> req0 granted first.
- pkt_count preloaded by sending 65535 packets, then one more -> pkt_count wraps to 0.
